// File: rtl/ex_mul_div.sv
// Iterative MULTU/MULT/DIVU/DIV unit for the EX stage, results kept in HI/LO.
// Latency: start accepted in cycle 0, done pulses in cycle WIDTH+3 for every op and operand.
// Backpressure: stall holds IF/ID and ID/EX from acceptance until the cycle before done.
// Ports: clock/resetN (async active-low); start/op/operandA/operandB come from the ID/EX
//   register outputs; flush aborts any operation; stall/busy/done report progress;
//   hi/lo hold the last result; divByZero flags that the last completed divide had a zero divisor.
module ex_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;          // raw operands, kept for sign and div-by-zero handling
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // mul: {hi, lo} product; div: {remainder, quotient}
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // op bit 0 selects the signed variant, bit 1 selects divide
  assign sign_a = op_q[0] & a_q[WIDTH-1];
  assign sign_b = op_q[0] & b_q[WIDTH-1];
  assign abs_a  = sign_a ? -a_q : a_q;
  assign abs_b  = sign_b ? -b_q : b_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    stall   = 1'b0;
    sum     = '0;
    trial   = '0;
    prod    = '0;
    quo     = '0;
    rem     = '0;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          stall   = 1'b1;
          state_d = PREP;
          op_d    = op;
          a_d     = operandA;
          b_d     = operandB;
          dbz_d   = 1'b0;
        end
      end
      PREP: begin
        stall   = 1'b1;
        state_d = RUN;
        cnt_d   = CW'(WIDTH);
        if (op_q[1]) begin
          acc_d = {{WIDTH{1'b0}}, abs_a};
          dvs_d = abs_b;
        end else begin
          acc_d = {{WIDTH{1'b0}}, abs_b};
          dvs_d = abs_a;
        end
      end
      RUN: begin
        stall = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
        if (op_q[1]) begin
          // Restoring step: shift {rem, quo} left, try subtracting the divisor from the
          // WIDTH+1-bit shifted remainder; no borrow means the quotient bit is 1.
          trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};
          if (!trial[WIDTH]) begin
            acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end
        end else begin
          // Shift-add: the low half holds the unconsumed multiplier bits.
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        stall   = 1'b1;
        state_d = DONE;
        if (op_q[1]) begin
          quo = acc_q[WIDTH-1:0];
          rem = acc_q[2*WIDTH-1:WIDTH];
          if (sign_a ^ sign_b) quo = -quo;
          if (sign_a)          rem = -rem;
          if (b_q == '0) begin
            quo = '1;
            rem = a_q;
          end
          hi_d  = rem;
          lo_d  = quo;
          dbz_d = (b_q == '0);
        end else begin
          prod = (sign_a ^ sign_b) ? -acc_q : acc_q;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Squash: abandon everything in flight, architectural results untouched.
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_ex_mul_div.sv
module tb_ex_mul_div;

  logic        clock = 1'b0;
  logic        resetN;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA, operandB;
  logic        flush;
  logic        stall, busy, done, divByZero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  ex_mul_div #(.WIDTH(32)) dut (
    .clock(clock), .resetN(resetN), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_cnt++;

  // Reference: {divByZero, hi, lo} from plain arithmetic on the architectural rules.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      2'd1: begin p = sa * sb; return {1'b0, p}; end
      2'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Called at negedge+1. Issues one instruction and follows it to done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input bit hold);
    int dc;
    bit stall_ok;
    start = 1'b1; op = o; operandA = a; operandB = b;
    if (busy) tick();  // previous op still in DONE: its instruction leaves ID/EX first
    #1;
    chk($sformatf("%s_stall_c0", tag), 64'(stall), 64'd1);
    dc = 0;
    stall_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 1) chk($sformatf("%s_dbz_clr", tag), 64'(divByZero), 64'd0);
      if (done) begin dc = n; break; end
      if (!stall) stall_ok = 1'b0;
    end
    chk($sformatf("%s_latency", tag), 64'(dc), 64'd35);
    chk($sformatf("%s_stall_run", tag), 64'(stall_ok), 64'd1);
    chk($sformatf("%s_stall_done", tag), 64'(stall), 64'd0);
    chk($sformatf("%s_hi", tag), 64'(hi), 64'(eh));
    chk($sformatf("%s_lo", tag), 64'(lo), 64'(el));
    chk($sformatf("%s_dbz", tag), 64'(divByZero), 64'(ed));
    exp_hi = eh;
    exp_lo = el;
    if (!hold) start = 1'b0;
  endtask

  task automatic run_model(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input bit hold);
    logic [64:0] m;
    m = model(o, a, b);
    run_op(tag, o, a, b, m[63:32], m[31:0], m[64], hold);
  endtask

  initial begin
    int dn0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    resetN = 1'b0; start = 1'b0; op = '0; operandA = '0; operandB = '0; flush = 1'b0;
    @(negedge clock); #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(divByZero), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    resetN = 1'b1;
    tick();

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);

    // Back-to-back with start held high through DONE
    tick(); tick();
    dn0 = done_cnt;
    run_op("b2b_mult", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
    run_op("b2b_multu", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);
    repeat (5) tick();
    chk("b2b_done_cnt", 64'(done_cnt - dn0), 64'd2);
    chk("b2b_idle", 64'(busy), 64'd0);

    run_op("divu", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("divu_z", 2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("multu_after_z", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

    // Flush at cycle 10 of a MULT
    tick();
    dn0 = done_cnt;
    start = 1'b1; op = 2'd1; operandA = 32'd1234; operandB = 32'hFFFF_FF00;
    repeat (10) tick();
    flush = 1'b1; start = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    repeat (40) tick();
    chk("flush_no_done", 64'(done_cnt - dn0), 64'd0);
    chk("flush_hi", 64'(hi), 64'(exp_hi));
    chk("flush_lo", 64'(lo), 64'(exp_lo));

    // Flush and start together in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; op = 2'd0; operandA = 32'd9; operandB = 32'd9;
    #1;
    chk("flush_start_stall", 64'(stall), 64'd0);
    tick();
    chk("flush_start_busy", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;
    tick();

    // Asynchronous reset at cycle 20 of a MULTU
    start = 1'b1; op = 2'd0; operandA = 32'hDEAD_BEEF; operandB = 32'h1234_5678;
    repeat (20) tick();
    resetN = 1'b0; start = 1'b0;
    #1;
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    tick();
    resetN = 1'b1;
    tick();
    run_op("post_rst", 2'd1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'd0, 32'd256, 1'b0, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 15));
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_model($sformatf("rnd%0d", i), ro, ra, rb, ($urandom_range(0, 1) == 1));
    end
    start = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
